// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake with a busy-rise timeout.
// Define UART_TXQ_OVF_CNT_EN to add the saturating dropped-write counter (ovfClr/ovfCnt).
module uart_tx_queue #(
    parameter int AW       = 4,
    parameter int BUSY_TMO = 4
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic [7:0]    wrData8,
    input  logic          wrEn,
`ifdef UART_TXQ_OVF_CNT_EN
    input  logic          ovfClr,
    output logic [7:0]    ovfCnt,
`endif
    output logic          fifoFull,
    output logic          fifoEmpty,
    output logic [AW:0]   fifoLevel,
    output logic [7:0]    txData8,
    output logic          txStart,
    input  logic          txBusy
);
    localparam int DEPTH = 1 << AW;
    localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);
    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_next;
    logic [TW-1:0] tmo_cnt;
    logic          wr_ok;
    logic          pop;

    // Full is sampled before the edge, so a write into a full FIFO is lost even if a pop frees a slot.
    assign wr_ok = wrEn && !fifoFull;
    assign pop   = (state == IDLE) && !fifoEmpty && !txBusy;

    always_comb begin
        level_next = fifoLevel;
        if (wr_ok && !pop) begin
            level_next = fifoLevel + (AW+1)'(1);
        end else if (!wr_ok && pop) begin
            level_next = fifoLevel - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wrData8;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoLevel <= '0;
            fifoEmpty <= 1'b1;
            fifoFull  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifoLevel <= level_next;
            fifoEmpty <= (level_next == '0);
            fifoFull  <= (level_next == LEVEL_MAX);
        end
    end

    // The head byte is latched on the pop edge and held until the next pop.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            txStart <= 1'b0;
            txData8 <= 8'h00;
            tmo_cnt <= '0;
        end else begin
            txStart <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= START;
                        txStart <= 1'b1;
                        txData8 <= mem[rd_ptr];
                    end
                end
                START: begin
                    state   <= WAIT_BUSY;
                    tmo_cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (txBusy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!txBusy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TXQ_OVF_CNT_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ovfCnt <= 8'h00;
        end else if (ovfClr) begin
            ovfCnt <= 8'h00;
        end else if (wrEn && fifoFull && (ovfCnt != 8'hFF)) begin
            ovfCnt <= ovfCnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed-plus-random bench for uart_tx_queue; a queue model tracks accepted bytes and delivery order.
module tb_uart_tx_queue;
    localparam int AW       = 4;
    localparam int BUSY_TMO = 4;
    localparam int DEPTH    = 1 << AW;

    logic        clk;
    logic        nRst;
    logic [7:0]  wrData8;
    logic        wrEn;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [AW:0] fifoLevel;
    logic [7:0]  txData8;
    logic        txStart;
    logic        txBusy;
`ifdef UART_TXQ_OVF_CNT_EN
    logic        ovfClr;
    logic [7:0]  ovfCnt;
    int          ovf_m;
`endif

    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [7:0] model_q[$];
    logic [7:0] data_log[$];
    int         start_log[$];
    logic [7:0] last_data;
    logic       prev_ts;
    int         busy_mode;
    logic       busy_force;
    int         rsp_delay;
    int         rsp_len;
    bit         rsp_rand;
    int         cfg_delay;
    int         cfg_len;
    int         last_busy_cyc;
    int         idx;
    int         guard;
    logic       we;

    uart_tx_queue #(.AW(AW), .BUSY_TMO(BUSY_TMO)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .wrData8   (wrData8),
        .wrEn      (wrEn),
`ifdef UART_TXQ_OVF_CNT_EN
        .ovfClr    (ovfClr),
        .ovfCnt    (ovfCnt),
`endif
        .fifoFull  (fifoFull),
        .fifoEmpty (fifoEmpty),
        .fifoLevel (fifoLevel),
        .txData8   (txData8),
        .txStart   (txStart),
        .txBusy    (txBusy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, want);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        last_data     = 8'h00;
        prev_ts       = 1'b0;
        rsp_delay     = 0;
        rsp_len       = 0;
        last_busy_cyc = -100;
`ifdef UART_TXQ_OVF_CNT_EN
        ovf_m = 0;
`endif
    endtask

    task automatic reset_checks(input string phase);
        check({phase, "_level"}, fifoLevel, 0);
        check({phase, "_empty"}, fifoEmpty, 1'b1);
        check({phase, "_full"}, fifoFull, 1'b0);
        check({phase, "_start"}, txStart, 1'b0);
        check({phase, "_data"}, txData8, 8'h00);
`ifdef UART_TXQ_OVF_CNT_EN
        check({phase, "_ovf"}, ovfCnt, 8'h00);
`endif
    endtask

    task automatic do_reset();
        wrEn   = 1'b0;
        txBusy = 1'b0;
        nRst   = 1'b0;
        #1;
        reset_checks("rst_async");
        @(posedge clk);
        #1;
        reset_checks("rst_hold");
        @(negedge clk);
        nRst = 1'b1;
        model_clear();
    endtask

    // One clock: drive inputs, let the edge happen, then update the model and compare.
    task automatic tick(input logic wen, input logic [7:0] d);
        int   sz;
        logic busy_pre;
        logic drop;
        wrEn    = wen;
        wrData8 = d;
        if (busy_mode == 0) begin
            txBusy = busy_force;
        end else if (rsp_delay > 0) begin
            txBusy = 1'b0;
            rsp_delay--;
        end else if (rsp_len > 0) begin
            txBusy = 1'b1;
            rsp_len--;
        end else begin
            txBusy = 1'b0;
        end
        busy_pre = txBusy;
        sz = model_q.size();
        @(posedge clk);
        #1;
        cyc++;
        if (busy_pre && busy_mode == 1) last_busy_cyc = cyc;
        if (txStart) begin
            check("start_width", prev_ts, 1'b0);
            check("start_not_busy", busy_pre, 1'b0);
            check("start_has_data", (sz > 0), 1'b1);
            if (busy_mode == 1) check("idle_gap", (cyc >= last_busy_cyc + 2), 1'b1);
            if (sz > 0) begin
                check("tx_data", txData8, model_q[0]);
                last_data = model_q.pop_front();
            end
            data_log.push_back(txData8);
            start_log.push_back(cyc);
            if (busy_mode == 1) begin
                rsp_delay = rsp_rand ? int'($urandom_range(0, 2)) : cfg_delay;
                rsp_len   = rsp_rand ? int'($urandom_range(1, 6)) : cfg_len;
            end
        end else begin
            check("data_hold", txData8, last_data);
        end
        drop = wen && (sz >= DEPTH);
        if (wen && !drop) model_q.push_back(d);
        check("level", fifoLevel, model_q.size());
        check("empty", fifoEmpty, (model_q.size() == 0));
        check("full", fifoFull, (model_q.size() == DEPTH));
`ifdef UART_TXQ_OVF_CNT_EN
        if (ovfClr) ovf_m = 0;
        else if (drop && ovf_m < 255) ovf_m++;
        check("ovf_cnt", ovfCnt, ovf_m);
`endif
        prev_ts = txStart;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((model_q.size() > 0 || rsp_delay > 0 || rsp_len > 0) && n < limit) begin
            tick(1'b0, 8'h00);
            n++;
        end
        check("drain_done", model_q.size(), 0);
        idle_ticks(BUSY_TMO + 4);
    endtask

    initial begin
        nRst       = 1'b1;
        wrEn       = 1'b0;
        wrData8    = 8'h00;
        txBusy     = 1'b0;
        busy_mode  = 0;
        busy_force = 1'b0;
        rsp_rand   = 1'b0;
        cfg_delay  = 1;
        cfg_len    = 20;
`ifdef UART_TXQ_OVF_CNT_EN
        ovfClr = 1'b0;
`endif
        model_clear();
        #3;
        do_reset();

        // Single byte: one-cycle start pulse one edge after the write.
        tick(1'b1, 8'hA5);
        check("lat_no_start_N", txStart, 1'b0);
        check("lat_level_N", fifoLevel, 1);
        tick(1'b0, 8'h00);
        check("lat_start_N1", txStart, 1'b1);
        check("lat_data", txData8, 8'hA5);
        check("lat_empty_after_pop", fifoEmpty, 1'b1);
        tick(1'b0, 8'h00);
        check("lat_start_low_N2", txStart, 1'b0);
        idle_ticks(BUSY_TMO + 4);

        // Busy never rises: START, BUSY_TMO cycles waiting, one IDLE, then the next byte.
        start_log.delete();
        tick(1'b1, 8'h33);
        tick(1'b1, 8'h44);
        drain(100);
        check("tmo_starts", start_log.size(), 2);
        if (start_log.size() == 2) check("tmo_gap", start_log[1] - start_log[0], BUSY_TMO + 2);

        // Busy gating with a 20-cycle frame per byte.
        busy_mode = 1; rsp_rand = 1'b0; cfg_delay = 1; cfg_len = 20; last_busy_cyc = -100;
        start_log.delete();
        data_log.delete();
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        drain(200);
        check("gate_starts", start_log.size(), 2);
        if (start_log.size() == 2) begin
            check("gate_gap", start_log[1] - start_log[0], cfg_delay + cfg_len + 2);
            check("gate_first", data_log[0], 8'h11);
            check("gate_second", data_log[1], 8'h22);
        end

        // Fill while busy, overflow by one, then drain.
        do_reset();
        busy_mode = 0; busy_force = 1'b1;
        for (int i = 0; i <= 16; i++) tick(1'b1, 8'(i));
        check("full_flag", fifoFull, 1'b1);
        check("full_level", fifoLevel, 16);
`ifdef UART_TXQ_OVF_CNT_EN
        check("ovf_one", ovfCnt, 8'h01);
        for (int i = 0; i < 260; i++) tick(1'b1, 8'hEE);
        check("ovf_sat", ovfCnt, 8'hFF);
        ovfClr = 1'b1;
        tick(1'b1, 8'hEE);
        ovfClr = 1'b0;
        check("ovf_clr_prio", ovfCnt, 8'h00);
        tick(1'b1, 8'hEE);
        check("ovf_after_clr", ovfCnt, 8'h01);
`endif
        data_log.delete();
        busy_mode = 1; rsp_rand = 1'b1; last_busy_cyc = -100;
        drain(1000);
        check("full_drain_count", data_log.size(), 16);
        foreach (data_log[i]) check("full_order", data_log[i], i);

        // Reset while a frame is in progress with bytes still queued.
        busy_mode = 1; rsp_rand = 1'b0; cfg_delay = 1; cfg_len = 20; last_busy_cyc = -100;
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h50 + i));
        idle_ticks(5);
        check("rst_pre_level", fifoLevel, 4);
        do_reset();
        busy_mode = 0; busy_force = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'h00);
            check("rst_no_start", txStart, 1'b0);
        end
        tick(1'b1, 8'h77);
        tick(1'b0, 8'h00);
        check("rst_restart", txStart, 1'b1);
        check("rst_restart_data", txData8, 8'h77);
        idle_ticks(BUSY_TMO + 4);

        // Wrap-around: 40 bytes with random writes and random transmitter timing.
        busy_mode = 1; rsp_rand = 1'b1; last_busy_cyc = -100;
        data_log.delete();
        idx = 0;
        guard = 0;
        while (idx < 40 && guard < 3000) begin
            we = (model_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            tick(we, 8'(idx));
            if (we) idx++;
            guard++;
        end
        check("wrap_written", idx, 40);
        drain(2000);
        check("wrap_count", data_log.size(), 40);
        foreach (data_log[i]) check("wrap_order", data_log[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter: AW, default 4, log2 of FIFO depth; depth = 2^AW entries of 8 bits.
REQ-002 Parameter: BUSY_TMO, default 4, number of clk cycles to wait for txBusy to rise after a txStart pulse.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 nRst  input  1  reset, asynchronous and active-low.
REQ-005 wrData8  input  8  byte from producer.
REQ-006 wrEn  input  1  write strobe; one byte is offered per cycle high.
REQ-007 fifoFull  output  1  high when level = 2^AW.
REQ-008 fifoEmpty  output  1  high when level = 0.
REQ-009 fifoLevel  output  AW+1  current number of stored bytes.
REQ-010 txData8  output  8  byte presented to the UART transmitter.
REQ-011 txStart  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 txBusy  input  1  transmitter busy flag, high while a frame is in progress.

Function
REQ-013 The FIFO shall be a circular buffer with AW-bit read/write pointers that wrap modulo 2^AW, plus a separate level counter.
REQ-014 A write shall be accepted when wrEn=1 and fifoFull=0; when fifoFull=1, wrEn shall be dropped even if a pop happens in the same cycle.
REQ-015 A simultaneous accepted write and pop shall leave fifoLevel unchanged.
REQ-016 The FSM shall have four states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE -> START when fifoEmpty=0 and txBusy=0; on that edge:
  - register the head byte into txData8;
  - set txStart=1;
  - pop one entry.
REQ-018 START -> WAIT_BUSY after exactly one cycle; txStart shall be high only in START.
REQ-019 WAIT_BUSY -> WAIT_DONE when txBusy=1. If txBusy stays low for BUSY_TMO cycles, WAIT_BUSY -> IDLE and the byte counts as sent.
REQ-020 WAIT_DONE -> IDLE when txBusy=0.
REQ-021 txData8 shall hold its value from the txStart pulse until the next txStart pulse.
REQ-022 Latency: a byte written into an empty FIFO at edge N, with txBusy=0, shall produce txStart high from edge N+1 to edge N+2.
REQ-023 Back-to-back bytes shall be separated by at least one IDLE cycle after txBusy falls.
REQ-024 fifoFull, fifoEmpty and fifoLevel shall be registered and shall reflect the state after each edge.

Reset
REQ-025 While nRst=0, the block shall hold these values:
  - pointers = 0, fifoLevel = 0;
  - fifoEmpty = 1, fifoFull = 0;
  - txStart = 0, txData8 = 8'h00;
  - FSM in IDLE.
REQ-026 Reset asserted mid-frame shall discard all queued bytes and any pending handshake. No txStart shall be issued until the FIFO is written again after reset release.
REQ-027 FIFO storage contents need no reset.

Configuration
REQ-028 Macro UART_TXQ_OVF_CNT_EN shall control the overflow counter.
  - Defined: add input ovfClr (1) and output ovfCnt (8). ovfCnt increments on each dropped write and saturates at 8'hFF. ovfCnt resets to 0 on nRst=0, and clears to 0 when ovfClr=1; ovfClr takes priority over an increment in the same cycle.
  - Undefined: neither port exists and dropped writes are silently discarded.

Verification
REQ-029 Single byte: write 8'hA5 into an empty FIFO with txBusy=0 -> txStart for exactly 1 cycle at N+1, txData8=8'hA5, fifoEmpty=1 after the pop.
REQ-030 Busy gating:
  - stimulus: write 8'h11, 8'h22; model txBusy high for 20 cycles after each txStart;
  - response: second txStart only after txBusy falls, output order 8'h11 then 8'h22.
REQ-031 Full/overflow (AW=4):
  - stimulus: hold txBusy=1 and write 17 bytes 8'h00..8'h10;
  - response: fifoFull=1 and fifoLevel=16; byte 8'h10 dropped; with macro defined, ovfCnt=1.
REQ-032 Timeout: txBusy held 0 after txStart -> return to IDLE after 4 cycles; the next queued byte starts with no deadlock.
REQ-033 Reset mid-operation:
  - stimulus: 5 bytes queued, pulse nRst low during WAIT_DONE;
  - response: fifoLevel=0, txStart=0, no further pulses after release.
REQ-034 Wrap-around: stream 40 bytes 8'h00..8'h27 through the AW=4 FIFO with random txBusy -> all bytes delivered in order with none lost.
